keypad_scan_debounce_param: RTL

// Parametrised matrix-keypad scanner and debouncer; generalises the fixed 4x4 scan FSM.
// - Drives one active-low row at a time and samples the column inputs.
// - Debounces both press and release; emits one registered key code per press.
// - Keeps a DEPTH-entry history of accepted keys for the multiplexed display path.

---
 rtl/keypad_scan_debounce_param.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_debounce_param.sv
// Purpose: matrix-keypad scanner; drives one active-low row at a time, debounces press and release,
//          emits one key code per accepted press and keeps a newest-first history of accepted keys.
// Latency: key_valid pulses DB_ON cycles after the sample cycle that captured the key; no backpressure (free-running).
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   col_sync   column inputs, already synchronised, active-low
//   clear      synchronous history clear, active-high
//   rows       row drive, one-hot active-low (all ones in reset)
//   key_code   last accepted key = row*COLS + col
//   key_valid  one-cycle pulse when key_code updates
//   key_held   high while the accepted key is down or in release debounce
//   history    entry i at [i*KEY_W +: KEY_W], entry 0 newest
//   hist_count number of valid history entries, saturates at DEPTH
module keypad_scan_debounce_param #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int SETTLE = 2,
  parameter int DB_ON  = 1024,
  parameter int DB_OFF = 8192,
  parameter int DEPTH  = 2,
  localparam int KEY_W = $clog2(ROWS*COLS),
  localparam int HC_W  = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COLS-1:0]        col_sync,
  input  logic                   clear,
  output logic [ROWS-1:0]        rows,
  output logic [KEY_W-1:0]       key_code,
  output logic                   key_valid,
  output logic                   key_held,
  output logic [DEPTH*KEY_W-1:0] history,
  output logic [HC_W-1:0]        hist_count
);

  localparam int RI_W  = $clog2(ROWS);
  localparam int CI_W  = $clog2(COLS);
  localparam int ST_W  = $clog2(SETTLE+1);
  localparam int DBN_W = $clog2(DB_ON+1);
  localparam int DBF_W = $clog2(DB_OFF+1);

  typedef enum logic [2:0] {
    S_SCAN     = 3'd0,
    S_PRESS_DB = 3'd1,
    S_EMIT     = 3'd2,
    S_HELD     = 3'd3,
    S_REL_DB   = 3'd4
  } state_t;

  state_t            state;
  logic [RI_W-1:0]   row_idx;
  logic [RI_W-1:0]   row_next;
  logic [ST_W-1:0]   settle_cnt;
  logic [DBN_W-1:0]  db_cnt;
  logic [DBF_W-1:0]  rel_cnt;
  logic [CI_W-1:0]   cap_col;
  logic              any_low;
  logic [CI_W-1:0]   low_col;
  logic [KEY_W-1:0]  new_code;

  // Lowest-index low column wins: scan downwards so the last hit is the lowest.
  always_comb begin
    any_low = 1'b0;
    low_col = '0;
    for (int i = COLS-1; i >= 0; i--) begin
      if (!col_sync[i]) begin
        any_low = 1'b1;
        low_col = CI_W'(i);
      end
    end
  end

  assign row_next = (row_idx == RI_W'(ROWS-1)) ? '0 : row_idx + RI_W'(1);
  assign new_code = KEY_W'(row_idx) * KEY_W'(COLS) + KEY_W'(cap_col);

  function automatic logic [ROWS-1:0] row_drive(input logic [RI_W-1:0] idx);
    row_drive = ~(ROWS'(1) << idx);
  endfunction

  // settle_cnt == 0 only right after reset/recovery: that cycle just starts
  // driving row 0, so the row appears on the cycle after reset deasserts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_SCAN;
      row_idx    <= '0;
      settle_cnt <= '0;
      db_cnt     <= '0;
      rel_cnt    <= '0;
      cap_col    <= '0;
      rows       <= '1;
      key_code   <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      history    <= '0;
      hist_count <= '0;
    end else begin
      key_valid <= 1'b0;
      // Plain clear; the EMIT branch below overrides it so the new key survives.
      if (clear) begin
        history    <= '0;
        hist_count <= '0;
      end
      case (state)
        S_SCAN: begin
          if (settle_cnt == ST_W'(SETTLE)) begin
            if (any_low) begin
              cap_col <= low_col;
              db_cnt  <= DBN_W'(1);
              state   <= S_PRESS_DB;
            end else begin
              row_idx    <= row_next;
              rows       <= row_drive(row_next);
              settle_cnt <= ST_W'(1);
            end
          end else begin
            rows       <= row_drive(row_idx);
            settle_cnt <= settle_cnt + ST_W'(1);
          end
        end
        S_PRESS_DB: begin
          if (!any_low) begin
            // Glitch: rescan the same row from a fresh settle period.
            settle_cnt <= ST_W'(1);
            state      <= S_SCAN;
          end else if (low_col != cap_col) begin
            cap_col <= low_col;
            db_cnt  <= DBN_W'(1);
          end else if (db_cnt == DBN_W'(DB_ON-1)) begin
            // Sample cycle counted as 1, so DB_ON stable cycles end here.
            db_cnt    <= DBN_W'(DB_ON);
            key_code  <= new_code;
            key_valid <= 1'b1;
            state     <= S_EMIT;
          end else begin
            db_cnt <= db_cnt + DBN_W'(1);
          end
        end
        S_EMIT: begin
          // History updates on the edge leaving EMIT, so a clear seen during
          // EMIT still keeps the freshly emitted code as entry 0.
          if (clear) begin
            history                <= '0;
            history[0 +: KEY_W]    <= key_code;
            hist_count             <= HC_W'(1);
          end else begin
            for (int i = DEPTH-1; i > 0; i--) begin
              history[i*KEY_W +: KEY_W] <= history[(i-1)*KEY_W +: KEY_W];
            end
            history[0 +: KEY_W] <= key_code;
            if (hist_count != HC_W'(DEPTH)) begin
              hist_count <= hist_count + HC_W'(1);
            end
          end
          key_held <= 1'b1;
          state    <= S_HELD;
        end
        S_HELD: begin
          if (!any_low) begin
            rel_cnt <= DBF_W'(1);
            state   <= S_REL_DB;
          end
        end
        S_REL_DB: begin
          if (any_low) begin
            rel_cnt <= '0;
            state   <= S_HELD;
          end else if (rel_cnt == DBF_W'(DB_OFF-1)) begin
            rel_cnt    <= '0;
            key_held   <= 1'b0;
            row_idx    <= row_next;
            rows       <= row_drive(row_next);
            settle_cnt <= ST_W'(1);
            state      <= S_SCAN;
          end else begin
            rel_cnt <= rel_cnt + DBF_W'(1);
          end
        end
        default: begin
          state      <= S_SCAN;
          row_idx    <= '0;
          settle_cnt <= '0;
          db_cnt     <= '0;
          rel_cnt    <= '0;
          rows       <= '1;
          key_held   <= 1'b0;
        end
      endcase
    end
  end

endmodule
